vga_timing_detector: RTL and testbench

- Receive-side counterpart of the board VGA timing generator.
- Samples incoming Hsync/Vsync on the pixel-rate enable and measures line length, hsync width, lines per frame and vsync width.
- Locks after LOCK_FRAMES consecutive identical frames, then publishes the measured mode and a recovered raster position.
- Used for loopback self-check of the video output and as the front end for a future video-capture path.

---
 rtl/vga_timing_detector_pkg.sv | 16 +
 rtl/vga_timing_detector_sync_edge.sv | 36 +++
 rtl/vga_timing_detector.sv | 230 +++++++++++++++++++++++
 tb/tb_vga_timing_detector.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_detector_pkg.sv
// Shared definitions for the VGA timing detector: FSM encoding and the
// 800x600@72 reference mode used by the generator and by benches.
package vga_timing_detector_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } det_state_t;

    localparam int SVGA72_LINE_LEN    = 1040;
    localparam int SVGA72_HS_WIDTH    = 120;
    localparam int SVGA72_FRAME_LINES = 666;
    localparam int SVGA72_VS_WIDTH    = 6;

endpackage

// File: rtl/vga_timing_detector_sync_edge.sv
// Two-flop synchronizer plus pix_en-gated edge detection for one sync input.
// Outputs are polarity-normalised: level=1 means "sync asserted".
module sync_edge #(
    parameter bit POL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pix_en,
    input  logic sync_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] meta;
    logic       norm;
    logic       prev;

    // NOTE: all state here is sequential, so only non-blocking assignments;
    // blocking ones would let a downstream flop see this cycle's new value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            prev <= 1'b0;
        end else begin
            meta <= {meta[0], sync_in};
            if (pix_en) prev <= norm;
        end
    end

    assign norm  = meta[1] ^ ~POL;
    assign level = norm;
    assign rise  = pix_en & norm & ~prev;
    assign fall  = pix_en & ~norm & prev;

endmodule

// File: rtl/vga_timing_detector.sv
// Measures incoming hsync/vsync timing, locks onto a stable mode after
// LOCK_FRAMES identical frames, then publishes the mode and raster position.
module vga_timing_detector
    import vga_timing_detector_pkg::*;
#(
    parameter int HCNT_W      = 11,
    parameter int VCNT_W      = 10,
    parameter int LOCK_FRAMES = 2,
    parameter bit HS_POL      = 1'b1,
    parameter bit VS_POL      = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_en,
    input  logic              hsync_in,
    input  logic              vsync_in,
    output logic              locked,
    output logic [HCNT_W-1:0] line_len,
    output logic [HCNT_W-1:0] hs_width,
    output logic [VCNT_W-1:0] frame_lines,
    output logic [VCNT_W-1:0] vs_width,
    output logic [HCNT_W-1:0] pix_x,
    output logic [VCNT_W-1:0] pix_y,
    output logic              frame_start,
    output logic              mode_change
);

    localparam logic [HCNT_W-1:0] H_MAX  = '1;
    localparam logic [VCNT_W-1:0] V_MAX  = '1;
    localparam logic [3:0]        LOCK_N = LOCK_FRAMES[3:0];

    typedef struct packed {
        logic [HCNT_W-1:0] len;
        logic [HCNT_W-1:0] hsw;
        logic [VCNT_W-1:0] lines;
        logic [VCNT_W-1:0] vsw;
    } mode_t;

    logic h_level, h_rise, h_fall;
    logic v_level, v_rise, v_fall;

    sync_edge #(.POL(HS_POL)) u_hs_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .pix_en  (pix_en),
        .sync_in (hsync_in),
        .level   (h_level),
        .rise    (h_rise),
        .fall    (h_fall)
    );

    sync_edge #(.POL(VS_POL)) u_vs_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .pix_en  (pix_en),
        .sync_in (vsync_in),
        .level   (v_level),
        .rise    (v_rise),
        .fall    (v_fall)
    );

    logic [HCNT_W-1:0] hcnt, hwcnt, cur_len, cur_hsw, first_len, h_len;
    logic [VCNT_W-1:0] vcnt, vwcnt, cur_lines, cur_vsw, v_lines;
    logic              line_timeout, first_valid, frame_bad, armed;
    logic [3:0]        match_cnt;
    det_state_t        state;
    mode_t             t_now, candidate, mode_q;

    assign h_len   = hcnt + 1'b1;
    assign v_lines = vcnt + 1'b1;

    // Tuple for the frame closing this cycle: uses the values being captured
    // now, so a line or frame ending on this edge is already included.
    assign t_now = '{len:   (h_rise ? h_len : cur_len),
                     hsw:   cur_hsw,
                     lines: v_lines,
                     vsw:   cur_vsw};

    // Horizontal measurement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt         <= '0;
            hwcnt        <= '0;
            cur_len      <= '0;
            cur_hsw      <= '0;
            line_timeout <= 1'b0;
        end else if (pix_en) begin
            if (h_rise) begin
                cur_len      <= h_len;
                hcnt         <= '0;
                line_timeout <= 1'b0;
            end else if (hcnt == H_MAX) begin
                line_timeout <= 1'b1;
            end else begin
                hcnt <= h_len;
            end

            if (h_rise)
                hwcnt <= '0;
            else if (h_level && hwcnt != H_MAX)
                hwcnt <= hwcnt + 1'b1;

            if (h_fall) cur_hsw <= hwcnt + 1'b1;
        end
    end

    // Vertical measurement; vsync wins over a coincident hsync for vcnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vcnt      <= '0;
            vwcnt     <= '0;
            cur_lines <= '0;
            cur_vsw   <= '0;
        end else if (pix_en) begin
            if (v_rise) begin
                cur_lines <= v_lines;
                vcnt      <= '0;
            end else if (h_rise && vcnt != V_MAX) begin
                vcnt <= v_lines;
            end

            if (v_rise)
                vwcnt <= VCNT_W'(h_rise);
            else if (v_level && h_rise && vwcnt != V_MAX)
                vwcnt <= vwcnt + 1'b1;

            if (v_fall) cur_vsw <= vwcnt;
        end
    end

    // Line-length consistency within a frame. The line ending on the vsync
    // edge belongs to the old frame, so it never seeds the new reference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_len   <= '0;
            first_valid <= 1'b0;
            frame_bad   <= 1'b0;
        end else if (v_rise) begin
            first_valid <= 1'b0;
            frame_bad   <= 1'b0;
        end else if (h_rise) begin
            if (!first_valid) begin
                first_len   <= h_len;
                first_valid <= 1'b1;
            end else if (h_len != first_len) begin
                frame_bad <= 1'b1;
            end
        end
    end

    // Lock FSM with registered status pulses and published mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_SEARCH;
            armed       <= 1'b0;
            match_cnt   <= '0;
            candidate   <= '0;
            mode_q      <= '0;
            locked      <= 1'b0;
            frame_start <= 1'b0;
            mode_change <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            mode_change <= 1'b0;
            case (state)
                ST_SEARCH: begin
                    if (v_rise) begin
                        if (!armed) begin
                            armed <= 1'b1;
                        end else if (!frame_bad) begin
                            candidate <= t_now;
                            match_cnt <= 4'd1;
                            if (LOCK_N <= 4'd1) begin
                                state  <= ST_LOCKED;
                                locked <= 1'b1;
                                mode_q <= t_now;
                            end else begin
                                state <= ST_VERIFY;
                            end
                        end
                    end
                end
                ST_VERIFY: begin
                    if (line_timeout || (v_rise && frame_bad)) begin
                        state <= ST_SEARCH;
                        armed <= 1'b0;
                    end else if (v_rise) begin
                        if (t_now == candidate) begin
                            if (match_cnt + 4'd1 >= LOCK_N) begin
                                state  <= ST_LOCKED;
                                locked <= 1'b1;
                                mode_q <= candidate;
                            end else begin
                                match_cnt <= match_cnt + 4'd1;
                            end
                        end else begin
                            candidate <= t_now;
                            match_cnt <= 4'd1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (line_timeout
                        || (h_rise && h_len != mode_q.len)
                        || (v_rise && (frame_bad || t_now != candidate))) begin
                        state       <= ST_SEARCH;
                        armed       <= 1'b0;
                        locked      <= 1'b0;
                        mode_change <= 1'b1;
                    end else if (v_rise) begin
                        frame_start <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_SEARCH;
                    armed  <= 1'b0;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    assign line_len    = mode_q.len;
    assign hs_width    = mode_q.hsw;
    assign frame_lines = mode_q.lines;
    assign vs_width    = mode_q.vsw;
    assign pix_x       = hcnt;
    assign pix_y       = vcnt;

endmodule

// File: tb/tb_vga_timing_detector.sv
// Scoreboard bench: stimulus pushes expected lock / frame_start / mode_change
// events; a monitor pops and checks them as the DUTs raise them.
`timescale 1ns/1ps
module tb_vga_timing_detector;
    import vga_timing_detector_pkg::*;

    localparam int HW = 11;
    localparam int VW = 10;

    typedef enum int {EV_LOCK = 0, EV_FS = 1, EV_MC = 2} ev_t;
    typedef struct {
        ev_t kind;
        int  dut;
        int  ll;
        int  hw;
        int  fl;
        int  vw;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   mc_count_a = 0;

    logic clk = 1'b0, pix_en = 1'b0, en_b = 1'b0, pix_en_b;
    logic rst_n = 1'b0, rst_b_n = 1'b0;
    logic hs_a = 1'b0, vs_a = 1'b0, hs_b = 1'b1, vs_b = 1'b1;
    logic sel_b = 1'b0;

    logic          a_locked, a_fs, a_mc, b_locked, b_fs, b_mc;
    logic [HW-1:0] a_line_len, a_hs_width, a_pix_x, b_line_len, b_hs_width, b_pix_x;
    logic [VW-1:0] a_frame_lines, a_vs_width, a_pix_y, b_frame_lines, b_vs_width, b_pix_y;
    logic          la_prev = 1'b0, lb_prev = 1'b0;

    assign pix_en_b = pix_en & en_b;

    vga_timing_detector #(.HCNT_W(HW), .VCNT_W(VW), .LOCK_FRAMES(2),
                          .HS_POL(1'b1), .VS_POL(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hsync_in(hs_a), .vsync_in(vs_a),
        .locked(a_locked), .line_len(a_line_len), .hs_width(a_hs_width),
        .frame_lines(a_frame_lines), .vs_width(a_vs_width), .pix_x(a_pix_x),
        .pix_y(a_pix_y), .frame_start(a_fs), .mode_change(a_mc)
    );

    vga_timing_detector #(.HCNT_W(HW), .VCNT_W(VW), .LOCK_FRAMES(2),
                          .HS_POL(1'b0), .VS_POL(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .pix_en(pix_en_b), .hsync_in(hs_b), .vsync_in(vs_b),
        .locked(b_locked), .line_len(b_line_len), .hs_width(b_hs_width),
        .frame_lines(b_frame_lines), .vs_width(b_vs_width), .pix_x(b_pix_x),
        .pix_y(b_pix_y), .frame_start(b_fs), .mode_change(b_mc)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(negedge clk);
        pix_en = ~pix_en;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: time limit reached with %0d expected events pending", sb.size());
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic push(input ev_t kind, input int d, input int ll, input int hw,
                        input int fl, input int vw);
        exp_t e;
        e.kind = kind; e.dut = d; e.ll = ll; e.hw = hw; e.fl = fl; e.vw = vw;
        sb.push_back(e);
    endtask

    task automatic handle(input ev_t kind, input int d);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected event: kind %0d on dut %0d, none expected", kind, d);
            return;
        end
        e = sb.pop_front();
        check("event kind", kind, e.kind);
        check("event dut", d, e.dut);
        case (kind)
            EV_LOCK: begin
                check("lock line_len",    d == 0 ? a_line_len    : b_line_len,    e.ll);
                check("lock hs_width",    d == 0 ? a_hs_width    : b_hs_width,    e.hw);
                check("lock frame_lines", d == 0 ? a_frame_lines : b_frame_lines, e.fl);
                check("lock vs_width",    d == 0 ? a_vs_width    : b_vs_width,    e.vw);
                check("lock no frame_start", d == 0 ? a_fs : b_fs, 0);
            end
            EV_FS: begin
                check("fs locked", d == 0 ? a_locked : b_locked, 1);
                check("fs pix_x",  d == 0 ? a_pix_x  : b_pix_x,  0);
                check("fs pix_y",  d == 0 ? a_pix_y  : b_pix_y,  0);
            end
            default: begin
                check("mc locked", d == 0 ? a_locked : b_locked, 0);
            end
        endcase
    endtask

    // Monitor: samples on the falling edge, away from the DUT's active edge.
    initial forever begin
        @(negedge clk);
        if (a_locked && !la_prev) handle(EV_LOCK, 0);
        if (a_fs) handle(EV_FS, 0);
        if (a_mc) begin
            mc_count_a++;
            handle(EV_MC, 0);
        end
        if (b_locked && !lb_prev) handle(EV_LOCK, 1);
        if (b_fs) handle(EV_FS, 1);
        if (b_mc) handle(EV_MC, 1);
        la_prev = a_locked;
        lb_prev = b_locked;
    end

    // One pixel: drive levels, hold until a pix_en edge has consumed them.
    task automatic tick(input logic h, input logic v);
        if (sel_b) begin
            hs_b = ~h;
            vs_b = ~v;
        end else begin
            hs_a = h;
            vs_a = v;
        end
        do @(posedge clk); while (!pix_en);
        #1;
    endtask

    task automatic frame(input int ll, input int hsw, input int nl, input int vsw,
                         input int long_line, input int drawn);
        for (int y = 0; y < drawn && y < nl; y++) begin
            int len;
            len = (y == long_line) ? ll + 1 : ll;
            for (int x = 0; x < len; x++) tick(x < hsw, y < vsw);
        end
    endtask

    task automatic frame_a();
        frame(40, 4, 12, 2, -1, 12);
    endtask

    task automatic reset_a();
        rst_n = 1'b0;
        hs_a  = 1'b0;
        vs_a  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int mc_before;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst locked",      a_locked, 0);
        check("rst line_len",    a_line_len, 0);
        check("rst hs_width",    a_hs_width, 0);
        check("rst frame_lines", a_frame_lines, 0);
        check("rst vs_width",    a_vs_width, 0);
        check("rst pix_x",       a_pix_x, 0);
        check("rst pix_y",       a_pix_y, 0);
        check("rst frame_start", a_fs, 0);
        check("rst mode_change", a_mc, 0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Acquire: edge 1 starts, edge 2 candidate, edge 3 locks.
        frame_a();
        frame_a();
        push(EV_LOCK, 0, 40, 4, 12, 2);
        frame_a();
        push(EV_FS, 0, 0, 0, 0, 0);
        frame_a();
        push(EV_FS, 0, 0, 0, 0, 0);
        frame_a();

        // One long line unlocks; relock three frames later.
        push(EV_FS, 0, 0, 0, 0, 0);
        push(EV_MC, 0, 0, 0, 0, 0);
        frame(40, 4, 12, 2, 5, 12);
        frame_a();
        frame_a();
        push(EV_LOCK, 0, 40, 4, 12, 2);
        frame_a();
        push(EV_FS, 0, 0, 0, 0, 0);
        frame_a();

        // hsync stuck long enough to saturate the pixel counter.
        push(EV_FS, 0, 0, 0, 0, 0);
        frame_a();
        push(EV_MC, 0, 0, 0, 0, 0);
        repeat (2100) tick(1'b0, 1'b0);
        check("timeout locked", a_locked, 0);
        frame_a();
        frame_a();
        push(EV_LOCK, 0, 40, 4, 12, 2);
        frame_a();

        // Asynchronous reset mid-frame while locked.
        push(EV_FS, 0, 0, 0, 0, 0);
        frame(40, 4, 12, 2, -1, 5);
        check("pending before reset", sb.size(), 0);
        rst_n = 1'b0;
        #1;
        check("mid rst locked",      a_locked, 0);
        check("mid rst line_len",    a_line_len, 0);
        check("mid rst frame_lines", a_frame_lines, 0);
        check("mid rst pix_x",       a_pix_x, 0);
        check("mid rst pix_y",       a_pix_y, 0);
        reset_a();
        frame_a();
        frame_a();
        push(EV_LOCK, 0, 40, 4, 12, 2);
        frame_a();
        push(EV_FS, 0, 0, 0, 0, 0);
        frame_a();

        // Alternating frame heights never lock.
        reset_a();
        mc_before = mc_count_a;
        for (int i = 0; i < 6; i++) frame(40, 4, (i % 2 == 0) ? 12 : 13, 2, -1, 13);
        check("alt locked", a_locked, 0);
        check("alt state", dut_a.state, ST_VERIFY);
        check("alt mode_change count", mc_count_a - mc_before, 0);

        // Inverted polarity, 100x20 raster with coincident frame-start edges.
        sel_b   = 1'b1;
        rst_b_n = 1'b1;
        repeat (6) @(posedge clk);
        #1 en_b = 1'b1;
        frame(100, 10, 20, 2, -1, 20);
        frame(100, 10, 20, 2, -1, 20);
        push(EV_LOCK, 1, 100, 10, 20, 2);
        frame(100, 10, 20, 2, -1, 20);
        push(EV_FS, 1, 0, 0, 0, 0);
        frame(100, 10, 20, 2, -1, 20);
        check("pol0 locked", b_locked, 1);

        repeat (10) @(posedge clk);
        #1;
        check("pending at end", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
